// File: rtl/ts_pkt_fetch_if.sv
// Bundles the J.83 byte-request side, the packet-buffer read side and the status
// outputs of ts_pkt_fetch. master = environment (J.83 + buffer), slave = fetcher.
// Handshake: byte_req, ts_rd_sync, ts_rd_req and ts_out_valid are single-cycle strobes
// with no backpressure; each byte_req earns exactly one ts_out_valid strobe later.
interface ts_pkt_fetch_if #(
  parameter int CNT_W = 16
);
  logic             byte_req;
  logic             has_frame;
  logic [7:0]       ts_rd_out;
  logic             ts_rd_sync;
  logic             ts_rd_req;
  logic [7:0]       ts_out;
  logic             ts_out_valid;
  logic             ts_out_sop;
  logic [CNT_W-1:0] real_pkt_cnt;
  logic [CNT_W-1:0] null_pkt_cnt;
  logic             sync_err;
  logic             req_ovf;

  modport master (
    output byte_req, has_frame, ts_rd_out,
    input  ts_rd_sync, ts_rd_req, ts_out, ts_out_valid, ts_out_sop,
    input  real_pkt_cnt, null_pkt_cnt, sync_err, req_ovf
  );

  modport slave (
    input  byte_req, has_frame, ts_rd_out,
    output ts_rd_sync, ts_rd_req, ts_out, ts_out_valid, ts_out_sop,
    output real_pkt_cnt, null_pkt_cnt, sync_err, req_ovf
  );
endinterface

// File: rtl/ts_pkt_fetch.sv
// Fetches whole TS packets from the packet buffer (or substitutes null packets) and
// emits them one byte per J.83 byte request, with SOP marking and packet statistics.
module ts_pkt_fetch #(
  parameter int PKT_LEN = 188,
  parameter int RD_LAT  = 4,
  parameter int CNT_W   = 16,
  parameter int PEND_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  ts_pkt_fetch_if.slave     bus,
  output logic [2:0]        dbg_state,
  output logic [PEND_W-1:0] dbg_pend
);
  localparam int IDX_W = $clog2(PKT_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_WAIT, S_LATCH, S_READ, S_DRAIN
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       sop;
    logic       is_real;
    logic [7:0] dat;
  } slot_t;

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              src_real_q, src_real_d;
  logic              drain_q, drain_d;
  logic [CNT_W-1:0]  real_cnt_q, real_cnt_d;
  logic [CNT_W-1:0]  null_cnt_q, null_cnt_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              sync_err_q, sync_err_d;
  slot_t             pipe_q [RD_LAT];
  slot_t             pipe_d [RD_LAT];

  logic       slot;
  logic       rd_sync;
  logic       pend_full;
  logic       pend_inc;
  logic [7:0] null_byte;
  slot_t      tap;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_real_d = src_real_q;
    drain_d    = drain_q;
    real_cnt_d = real_cnt_q;
    null_cnt_d = null_cnt_q;
    slot       = 1'b0;
    rd_sync    = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_SYNC;
      S_SYNC: begin
        rd_sync = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        src_real_d = bus.has_frame;
        if (bus.has_frame) real_cnt_d = real_cnt_q + CNT_W'(1);
        else               null_cnt_d = null_cnt_q + CNT_W'(1);
        idx_d   = '0;
        state_d = S_READ;
      end
      S_READ: begin
        if (pend_q != '0) begin
          slot  = 1'b1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(PKT_LEN - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Two idle cycles so the buffer finishes the last read before the next sync.
        drain_d = ~drain_q;
        if (drain_q) state_d = S_SYNC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request at saturation still counts when a slot frees an entry in the same cycle.
  always_comb begin
    pend_full = (pend_q == '1);
    pend_inc  = bus.byte_req && (!pend_full || slot);
    ovf_d     = ovf_q || (bus.byte_req && pend_full && !slot);
    pend_d    = pend_q + PEND_W'(pend_inc) - PEND_W'(slot);
  end

  always_comb begin
    null_byte = 8'hFF;
    if (idx_q == IDX_W'(0))      null_byte = 8'h47;
    else if (idx_q == IDX_W'(1)) null_byte = 8'h1F;
    else if (idx_q == IDX_W'(3)) null_byte = 8'h10;
  end

  // Slot descriptors travel alongside the buffer read latency and meet ts_rd_out at the tap.
  always_comb begin
    pipe_d[0] = '{valid: slot, sop: slot && (idx_q == '0), is_real: src_real_q, dat: null_byte};
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    tap         = pipe_q[RD_LAT-1];
    out_d       = out_q;
    out_valid_d = tap.valid;
    out_sop_d   = tap.valid && tap.sop;
    sync_err_d  = tap.valid && tap.sop && tap.is_real && (bus.ts_rd_out != 8'h47);
    if (tap.valid) out_d = tap.is_real ? bus.ts_rd_out : tap.dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      src_real_q  <= 1'b0;
      drain_q     <= 1'b0;
      real_cnt_q  <= '0;
      null_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      src_real_q  <= src_real_d;
      drain_q     <= drain_d;
      real_cnt_q  <= real_cnt_d;
      null_cnt_q  <= null_cnt_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      sync_err_q  <= sync_err_d;
      pipe_q      <= pipe_d;
    end
  end

  assign bus.ts_rd_sync   = rd_sync;
  assign bus.ts_rd_req    = slot && src_real_q;
  assign bus.ts_out       = out_q;
  assign bus.ts_out_valid = out_valid_q;
  assign bus.ts_out_sop   = out_sop_q;
  assign bus.real_pkt_cnt = real_cnt_q;
  assign bus.null_pkt_cnt = null_cnt_q;
  assign bus.sync_err     = sync_err_q;
  assign bus.req_ovf      = ovf_q;
  assign dbg_state        = state_q;
  assign dbg_pend         = pend_q;
endmodule

// File: tb/tb_ts_pkt_fetch.sv
// Directed bench for ts_pkt_fetch: buffer model with 4-cycle read latency, expected
// output bytes queued per packet at the sync point and popped on ts_out_valid.
module tb_ts_pkt_fetch;
  localparam int PKT_LEN = 188;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;
  logic [3:0] dbg_pend;

  always #4 clk = ~clk;

  ts_pkt_fetch_if #(.CNT_W(16)) bus ();

  ts_pkt_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_pend  (dbg_pend)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_req = 0;
  int         n_out = 0;
  int         n_err_pulse = 0;
  bit         sb_en = 1'b1;
  logic [9:0] exp_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] rd_pipe [3];

  int         cur_npkts;
  int         cur_gap;
  logic [7:0] cur_plan;
  logic [7:0] cur_first;
  int         cur_real;
  int         cur_null;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Buffer model: data for a read request appears on ts_rd_out 4 cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe[0] <= 8'h00;
      rd_pipe[1] <= 8'h00;
      rd_pipe[2] <= 8'h00;
      bus.ts_rd_out <= 8'h00;
    end else begin
      if (bus.ts_rd_req) rd_pipe[0] <= (buf_q.size() > 0) ? buf_q.pop_front() : 8'hEE;
      rd_pipe[1]    <= rd_pipe[0];
      rd_pipe[2]    <= rd_pipe[1];
      bus.ts_rd_out <= rd_pipe[2];
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (bus.ts_rd_req) n_req++;
      if (bus.sync_err)  n_err_pulse++;
      if (sb_en && bus.ts_out_valid) begin
        n_out++;
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ts_out", bus.ts_out, e[7:0]);
          chk("ts_out_sop", bus.ts_out_sop, e[8]);
          chk("sync_err", bus.sync_err, e[9]);
        end
      end
    end
  end

  task automatic push_pkt(input bit is_real, input logic [7:0] first, input logic [7:0] salt);
    logic [7:0] b;
    for (int i = 0; i < PKT_LEN; i++) begin
      if (is_real) begin
        b = (i == 0) ? first : (8'(i - 1) ^ salt);
        buf_q.push_back(b);
      end else begin
        b = (i == 0) ? 8'h47 : (i == 1) ? 8'h1F : (i == 3) ? 8'h10 : 8'hFF;
      end
      exp_q.push_back({is_real && (i == 0) && (b != 8'h47), (i == 0), b});
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.byte_req  = 1'b0;
    bus.has_frame = 1'b0;
    exp_q.delete();
    buf_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_sync(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (bus.ts_rd_sync) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sync_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_pkts(input int npkts, input logic [7:0] plan, input int gap, input logic [7:0] first);
    int req0;
    cur_npkts = npkts;
    cur_plan  = plan;
    cur_gap   = gap;
    cur_first = first;
    cur_real  = 0;
    cur_null  = 0;
    do_reset();
    req0 = n_req;
    fork
      begin
        for (int k = 0; k < cur_npkts * PKT_LEN; k++) begin
          bus.byte_req = 1'b1;
          @(negedge clk);
          bus.byte_req = 1'b0;
          repeat (cur_gap - 1) @(negedge clk);
        end
      end
      begin
        bit ok;
        for (int p = 0; p <= cur_npkts; p++) begin
          wait_sync(ok);
          if (!ok) break;
          if (p == cur_npkts) begin
            chk("real_pkt_cnt", bus.real_pkt_cnt, 32'(cur_real));
            chk("null_pkt_cnt", bus.null_pkt_cnt, 32'(cur_null));
            bus.has_frame = 1'b0;
          end else begin
            bus.has_frame = cur_plan[p];
            if (cur_plan[p]) cur_real++;
            else             cur_null++;
            push_pkt(cur_plan[p], (p == 0) ? cur_first : 8'h47, 8'(p));
          end
        end
      end
    join
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_req_cnt", 32'(n_req - req0), 32'(cur_real * PKT_LEN));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int o0;
    bit ok;
    bus.byte_req  = 1'b0;
    bus.has_frame = 1'b0;
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state and first sync position.
    chk("rst_state", dbg_state, 32'd0);
    chk("rst_ts_out", bus.ts_out, 32'd0);
    chk("rst_valid", bus.ts_out_valid, 32'd0);
    chk("rst_req_ovf", bus.req_ovf, 32'd0);
    chk("rst_real_cnt", bus.real_pkt_cnt, 32'd0);
    chk("rst_null_cnt", bus.null_pkt_cnt, 32'd0);
    rst = 1'b0;
    chk("sync_cycle1", bus.ts_rd_sync, 32'd0);
    @(negedge clk);
    chk("sync_cycle2", bus.ts_rd_sync, 32'd1);

    // Empty buffer: one null packet.
    run_pkts(1, 8'b0, 1, 8'h47);

    // One real packet, then one with a corrupt sync byte.
    e0 = n_err_pulse;
    run_pkts(1, 8'b1, 1, 8'h47);
    chk("no_sync_err", 32'(n_err_pulse - e0), 32'd0);
    e0 = n_err_pulse;
    run_pkts(1, 8'b1, 1, 8'h48);
    chk("one_sync_err", 32'(n_err_pulse - e0), 32'd1);

    // Sparse requests with alternating real/null packets.
    run_pkts(4, 8'b0101, 3, 8'h47);

    // Continuous requests: gaps accumulate pend until it saturates.
    do_reset();
    sb_en = 1'b0;
    bus.byte_req = 1'b1;
    repeat (400) @(negedge clk);
    chk("ovf_not_yet", bus.req_ovf, 32'd0);
    repeat (500) @(negedge clk);
    chk("ovf_set", bus.req_ovf, 32'd1);
    chk("pend_sat", dbg_pend, 32'd15);
    bus.byte_req = 1'b0;
    repeat (300) @(negedge clk);
    chk("ovf_sticky", bus.req_ovf, 32'd1);
    sb_en = 1'b1;

    // Reset in the middle of a real packet.
    do_reset();
    wait_sync(ok);
    bus.has_frame = 1'b1;
    push_pkt(1'b1, 8'h47, 8'h5A);
    o0 = n_out;
    bus.byte_req = 1'b1;
    for (int c = 0; c < 400 && (n_out - o0) < 100; c++) @(negedge clk);
    chk("mid_pkt_reached", 32'(n_out - o0), 32'd100);
    rst = 1'b1;
    bus.byte_req = 1'b0;
    #1;
    chk("mid_rst_valid", bus.ts_out_valid, 32'd0);
    chk("mid_rst_out", bus.ts_out, 32'd0);
    chk("mid_rst_req", bus.ts_rd_req, 32'd0);
    chk("mid_rst_real_cnt", bus.real_pkt_cnt, 32'd0);
    exp_q.delete();
    buf_q.delete();
    bus.has_frame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("re_sync_cycle1", bus.ts_rd_sync, 32'd0);
    @(negedge clk);
    chk("re_sync_cycle2", bus.ts_rd_sync, 32'd1);
    push_pkt(1'b0, 8'h47, 8'h00);
    for (int k = 0; k < PKT_LEN; k++) begin
      bus.byte_req = 1'b1;
      @(negedge clk);
      bus.byte_req = 1'b0;
    end
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    chk("re_pkt_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
